// File: rtl/shift_mult_pkg.sv
// rtl/shift_mult_pkg.sv - shared constants and types for the shift multiplier datapath
package shift_mult_pkg;

  // Default operand width of the multiplier datapath.
  localparam int OPERAND_W = 11;

  // Serial bit order, shared by the shift-in and shift-out blocks.
  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } bit_order_e;

  // Width of a counter that must hold values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_in_deser_if.sv
// rtl/shift_in_deser_if.sv - serial-in / parallel-out handshake bundle of the operand loader
interface shift_in_deser_if
  import shift_mult_pkg::*;
#(
  parameter int W = OPERAND_W
) ();

  localparam int CW = cnt_width(W);

  logic          X_in;
  logic          sx;
  logic          sx_ready;
  logic          flush;
  logic [W-1:0]  x_par;
  logic          par_valid;
  logic          par_ready;
  logic [CW-1:0] bit_cnt;
  logic          stall;

  // Producer / core side of the loader.
  modport master (
    output X_in, sx, flush, par_ready,
    input  sx_ready, x_par, par_valid, bit_cnt, stall
  );

  // The loader itself.
  modport slave (
    input  X_in, sx, flush, par_ready,
    output sx_ready, x_par, par_valid, bit_cnt, stall
  );

endinterface

// File: rtl/shift_in_hold_reg.sv
// rtl/shift_in_hold_reg.sv - W-bit valid/ready holding register with a load port
module shift_in_hold_reg
  import shift_mult_pkg::*;
#(
  parameter int W = OPERAND_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         hold_free
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // A load wins over a consume, so consume+load keeps valid high with the new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; data only ever changes on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign hold_free = !valid_q || ready;

endmodule

// File: rtl/shift_in_deser.sv
// rtl/shift_in_deser.sv - serial-to-parallel operand loader with double-buffered output
module shift_in_deser
  import shift_mult_pkg::*;
#(
  parameter int W         = OPERAND_W,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(W + 1)
) (
  input logic             clk,
  input logic             rst_n,
  shift_in_deser_if.slave bus
);

  localparam bit_order_e    ORDER    = bit_order_e'(MSB_FIRST);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [W-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  next_word;
  logic [W-1:0]  load_data;
  logic          load;
  logic          hold_free;
  logic          sx_ready;
  logic          accept;

  assign sx_ready = (cnt_q < CNT_FULL);
  assign accept   = bus.sx && sx_ready;

  // Shift register contents after absorbing the current serial bit.
  always_comb begin
    next_word = shreg_q;
    if (ORDER == ORDER_MSB_FIRST) begin
      next_word = {shreg_q[W-2:0], bus.X_in};
    end else begin
      next_word = {bus.X_in, shreg_q[W-1:1]};
    end
  end

  // Shift, count and load control: flush > accept > drain of a stalled full word.
  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = next_word;
    if (bus.flush) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (cnt_q == CNT_LAST) begin
        if (hold_free) begin
          // Last bit goes straight to the holding register.
          load    = 1'b1;
          shreg_d = '0;
          cnt_d   = '0;
        end else begin
          shreg_d = next_word;
          cnt_d   = CNT_FULL;
        end
      end else begin
        shreg_d = next_word;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if ((cnt_q == CNT_FULL) && hold_free) begin
      // Stalled full word moves over once the holding register frees up.
      load      = 1'b1;
      load_data = shreg_q;
      shreg_d   = '0;
      cnt_d     = '0;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_in_hold_reg #(
    .W(W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(load_data),
    .ready    (bus.par_ready),
    .data     (bus.x_par),
    .valid    (bus.par_valid),
    .hold_free(hold_free)
  );

  assign bus.sx_ready = sx_ready;
  assign bus.bit_cnt  = cnt_q;
  assign bus.stall    = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_shift_in_deser.sv
// tb/tb_shift_in_deser.sv - randomized self-checking bench for shift_in_deser
module tb_shift_in_deser;

  localparam int WA = 11;
  localparam int WB = 8;

  logic clk;
  logic rst_n;

  shift_in_deser_if #(.W(WA)) ifa ();
  shift_in_deser_if #(.W(WB)) ifb ();

  shift_in_deser #(.W(WA), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  shift_in_deser #(.W(WB), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: list of received bits, holding word and its valid flag.
  int          m_cnt   [2];
  logic [15:0] m_bits  [2];
  logic [15:0] m_word  [2];
  bit          m_valid [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] assemble(input int w, input bit msb, input logic [15:0] b);
    logic [15:0] r = '0;
    for (int i = 0; i < w; i++) begin
      if (msb) r[w-1-i] = b[i];
      else     r[i]     = b[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_bits[d] = '0; m_word[d] = '0; m_valid[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input int w, input bit msb,
                            input bit sx, input bit x, input bit fl, input bit rdy);
    bit free   = !m_valid[d] || rdy;
    bit loaded = 1'b0;
    bit full   = 1'b0;
    if (fl) begin
      m_cnt[d] = 0; m_bits[d] = '0;
    end else if (sx && m_cnt[d] < w) begin
      m_bits[d][m_cnt[d]] = x;
      m_cnt[d]++;
      full = (m_cnt[d] == w) && free;
    end else if (m_cnt[d] == w && free) begin
      full = 1'b1;
    end
    if (full) begin
      m_word[d] = assemble(w, msb, m_bits[d]);
      m_valid[d] = 1'b1; m_cnt[d] = 0; m_bits[d] = '0; loaded = 1'b1;
    end
    if (!loaded && m_valid[d] && rdy) m_valid[d] = 1'b0;
  endtask

  task automatic check_all();
    chk("a.x_par",     32'(ifa.x_par),     32'(m_word[0]));
    chk("a.par_valid", 32'(ifa.par_valid), 32'(m_valid[0]));
    chk("a.bit_cnt",   32'(ifa.bit_cnt),   32'(m_cnt[0]));
    chk("a.sx_ready",  32'(ifa.sx_ready),  32'(m_cnt[0] < WA));
    chk("a.stall",     32'(ifa.stall),     32'(m_cnt[0] == WA));
    chk("b.x_par",     32'(ifb.x_par),     32'(m_word[1]));
    chk("b.par_valid", 32'(ifb.par_valid), 32'(m_valid[1]));
    chk("b.bit_cnt",   32'(ifb.bit_cnt),   32'(m_cnt[1]));
    chk("b.sx_ready",  32'(ifb.sx_ready),  32'(m_cnt[1] < WB));
    chk("b.stall",     32'(ifb.stall),     32'(m_cnt[1] == WB));
  endtask

  // One clock: drive at the negedge, model at the posedge, check at the next negedge.
  task automatic cycle(input bit asx, input bit ax, input bit afl, input bit ardy,
                       input bit bsx, input bit bx, input bit bfl, input bit brdy);
    ifa.sx = asx; ifa.X_in = ax; ifa.flush = afl; ifa.par_ready = ardy;
    ifb.sx = bsx; ifb.X_in = bx; ifb.flush = bfl; ifb.par_ready = brdy;
    @(posedge clk);
    model_step(0, WA, 1'b1, asx, ax, afl, ardy);
    model_step(1, WB, 1'b0, bsx, bx, bfl, brdy);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic send_a(input logic [WA-1:0] w, input bit rdy);
    for (int i = 0; i < WA; i++) cycle(1'b1, w[WA-1-i], 1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [WA-1:0] wa, wb2;
    logic [WB-1:0] wbyte;
    int pulses[$];
    logic [WA-1:0] words[$];

    rst_n = 1'b0;
    ifa.sx = 1'b0; ifa.X_in = 1'b0; ifa.flush = 1'b0; ifa.par_ready = 1'b0;
    ifb.sx = 1'b0; ifb.X_in = 1'b0; ifb.flush = 1'b0; ifb.par_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // MSB-first word on the W=11 instance.
    wa = 11'h536;
    send_a(wa, 1'b1);
    chk("msb.valid", 32'(ifa.par_valid), 32'd1);
    chk("msb.x_par", 32'(ifa.x_par), 32'h536);
    idle(1);
    chk("msb.pulse_end", 32'(ifa.par_valid), 32'd0);

    // LSB-first 0xA5 on the W=8 instance.
    wbyte = 8'hA5;
    for (int i = 0; i < WB; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, wbyte[i], 1'b0, 1'b1);
    chk("lsb.x_par", 32'(ifb.x_par), 32'hA5);
    chk("lsb.bit_cnt", 32'(ifb.bit_cnt), 32'd0);
    idle(1);

    // Streaming: three back-to-back words with the core always ready.
    for (int k = 0; k < 3; k++) begin
      wa = WA'($urandom);
      words.push_back(wa);
      for (int i = 0; i < WA; i++) begin
        cycle(1'b1, wa[WA-1-i], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stream.sx_ready", 32'(ifa.sx_ready), 32'd1);
        if (ifa.par_valid) begin
          pulses.push_back(cyc);
          chk("stream.word", 32'(ifa.x_par), 32'(words[pulses.size()-1]));
        end
      end
    end
    chk("stream.pulses", 32'(pulses.size()), 32'd3);
    for (int j = 1; j < pulses.size(); j++)
      chk("stream.spacing", 32'(pulses[j] - pulses[j-1]), 32'(WA));
    idle(1);

    // Backpressure: word A held, word B stalls in the shift register.
    wa  = WA'($urandom);
    wb2 = WA'($urandom);
    send_a(wa, 1'b0);
    send_a(wb2, 1'b0);
    chk("bp.bit_cnt", 32'(ifa.bit_cnt), 32'(WA));
    chk("bp.stall", 32'(ifa.stall), 32'd1);
    chk("bp.sx_ready", 32'(ifa.sx_ready), 32'd0);
    chk("bp.x_par_a", 32'(ifa.x_par), 32'(wa));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp.ignored", 32'(ifa.bit_cnt), 32'(WA));
    chk("bp.x_par_stable", 32'(ifa.x_par), 32'(wa));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp.x_par_b", 32'(ifa.x_par), 32'(wb2));
    chk("bp.valid_b", 32'(ifa.par_valid), 32'd1);
    chk("bp.cnt_clear", 32'(ifa.bit_cnt), 32'd0);
    idle(1);

    // Flush at bit_cnt=5 with a word pending.
    wa = WA'($urandom);
    send_a(wa, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fl.cnt5", 32'(ifa.bit_cnt), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fl.cnt0", 32'(ifa.bit_cnt), 32'd0);
    chk("fl.x_par", 32'(ifa.x_par), 32'(wa));
    chk("fl.valid", 32'(ifa.par_valid), 32'd1);
    wb2 = WA'($urandom);
    send_a(wb2, 1'b1);
    chk("fl.clean_word", 32'(ifa.x_par), 32'(wb2));
    chk("fl.clean_valid", 32'(ifa.par_valid), 32'd1);

    // Random traffic on both instances.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(15) == 0), 1'($urandom),
            ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(15) == 0), 1'($urandom));
    end

    // Asynchronous reset mid-operation, checked before any clock edge.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.a.x_par", 32'(ifa.x_par), 32'd0);
    chk("rst.a.valid", 32'(ifa.par_valid), 32'd0);
    chk("rst.a.cnt", 32'(ifa.bit_cnt), 32'd0);
    chk("rst.a.sx_ready", 32'(ifa.sx_ready), 32'd1);
    chk("rst.a.stall", 32'(ifa.stall), 32'd0);
    chk("rst.b.x_par", 32'(ifb.x_par), 32'd0);
    chk("rst.b.valid", 32'(ifb.par_valid), 32'd0);
    chk("rst.b.cnt", 32'(ifb.bit_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cycle(1'($urandom), 1'($urandom), ($urandom_range(15) == 0), 1'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(15) == 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
